// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stream front end: FSM state encoding and default widths.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CNT_WIDTH  = 10;

endpackage

// File: rtl/axis_sync_fifo.sv
// Small first-word-fall-through FIFO: storage, wrap pointers with an extra lap bit, full/empty flags.
module axis_sync_fifo #(
    parameter int pWIDTH = 33,
    parameter int pDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [pWIDTH-1:0] i_wdata,
    input  logic              i_pop,
    output logic [pWIDTH-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(pDEPTH);

    logic [pWIDTH-1:0] r_mem [pDEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    // Same index but different lap bit means the writer is a full lap ahead.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/axis_in_buf.sv
// AXI-Stream input buffer feeding the FIR dataflow; frame FSM IDLE/RUN/DRAIN around a small FIFO.
// Beat counter data_cnt is built only when AXIS_IN_BUF_CNT_EN is defined; otherwise it reads 0.
module axis_in_buf
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
    parameter int pFIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int pCNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tvalid,
    input  logic [pDATA_WIDTH-1:0] tdata,
    input  logic                   tlast,
    output logic                   tready,
    output logic [pDATA_WIDTH-1:0] strm_data,
    output logic                   strm_valid,
    output logic                   strm_last,
    input  logic                   fir_ready,
    input  logic                   ap_start,
    output logic                   axis_finish,
    output logic [pCNT_WIDTH-1:0]  data_cnt
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_finish;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last_pop;
    logic [pDATA_WIDTH:0]   w_head;

    axis_sync_fifo #(
        .pWIDTH (pDATA_WIDTH + 1),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({tlast, tdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Full blocks acceptance even when the head is leaving this cycle.
    assign tready     = (r_state == RUN) & ~w_full;
    assign w_push     = tvalid & tready;
    assign w_pop      = ~w_empty & fir_ready;
    assign w_last_pop = w_pop & w_head[pDATA_WIDTH] & (r_state == DRAIN);

    assign strm_valid  = ~w_empty;
    assign strm_last   = ~w_empty & w_head[pDATA_WIDTH];
    assign strm_data   = w_empty ? '0 : w_head[pDATA_WIDTH-1:0];
    assign axis_finish = r_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_finish <= w_last_pop;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ap_start)          w_state_next = RUN;
            RUN:     if (w_push && tlast)   w_state_next = DRAIN;
            DRAIN:   if (w_last_pop)        w_state_next = IDLE;
            default:                        w_state_next = IDLE;
        endcase
    end

`ifdef AXIS_IN_BUF_CNT_EN
    logic [pCNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && ap_start) begin
            r_cnt <= '0;
        end else if (w_push && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign data_cnt = r_cnt;
`else
    assign data_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_in_buf.sv
// Directed bench for axis_in_buf: beat source queue, scoreboard of buffered beats, reference frame state.
module tb_axis_in_buf;
    import fir_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tvalid = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic          tlast = 1'b0;
    logic          fir_ready = 1'b0;
    logic          ap_start = 1'b0;
    logic          tready;
    logic [DW-1:0] strm_data;
    logic          strm_valid;
    logic          strm_last;
    logic          axis_finish;
    logic [CW-1:0] data_cnt;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         src_q[$];
    beat_t         sb[$];
    int            checks = 0;
    int            failures = 0;
    int            exp_state = 0;
    int            n_acc = 0;
    logic [CW-1:0] exp_cnt = '0;

    axis_in_buf #(
        .pDATA_WIDTH (DW),
        .pFIFO_DEPTH (DEPTH),
        .pCNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tvalid      (tvalid),
        .tdata       (tdata),
        .tlast       (tlast),
        .tready      (tready),
        .strm_data   (strm_data),
        .strm_valid  (strm_valid),
        .strm_last   (strm_last),
        .fir_ready   (fir_ready),
        .ap_start    (ap_start),
        .axis_finish (axis_finish),
        .data_cnt    (data_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef AXIS_IN_BUF_CNT_EN
        chk(tag, 64'(data_cnt), 64'(exp_cnt));
`else
        chk(tag, 64'(data_cnt), 64'd0);
`endif
    endtask

    task automatic add_beats(input logic [DW-1:0] first, input int n, input logic last_on_end);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = first + DW'(i);
            b.last = last_on_end && (i == n - 1);
            src_q.push_back(b);
        end
    endtask

    // One clock cycle: called just after a falling edge, returns just after the next one.
    task automatic tick();
        logic  acc;
        logic  pop;
        logic  fin_exp;
        int    nst;
        beat_t h;
        if (src_q.size() != 0) begin
            tvalid = 1'b1;
            tdata  = src_q[0].data;
            tlast  = src_q[0].last;
        end else begin
            tvalid = 1'b0;
            tdata  = '0;
            tlast  = 1'b0;
        end
        #1;
        chk("tready", 64'(tready), 64'(exp_state == 1 && sb.size() < DEPTH));
        chk("strm_valid", 64'(strm_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("strm_data", 64'(strm_data), 64'(sb[0].data));
            chk("strm_last", 64'(strm_last), 64'(sb[0].last));
        end else begin
            chk("strm_data_empty", 64'(strm_data), 64'd0);
        end
        acc     = tvalid && tready;
        pop     = strm_valid && fir_ready;
        fin_exp = 1'b0;
        nst     = exp_state;
        if (pop && sb.size() != 0) begin
            h = sb.pop_front();
            $display("pop  data=%08h last=%0b", h.data, h.last);
            if (h.last && exp_state == 2) begin
                fin_exp = 1'b1;
                nst     = 0;
            end
        end
        if (acc) begin
            h = src_q.pop_front();
            sb.push_back(h);
            n_acc++;
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            if (h.last) nst = 2;
            $display("push data=%08h last=%0b", h.data, h.last);
        end
        if (exp_state == 0 && ap_start) begin
            nst     = 1;
            exp_cnt = '0;
        end
        exp_state = nst;
        @(negedge clk);
        chk("axis_finish", 64'(axis_finish), 64'(fin_exp));
        chk_cnt("data_cnt");
    endtask

    task automatic start_frame();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        int i;
        i = 0;
        while (i < budget && !(exp_state == 0 && sb.size() == 0 && src_q.size() == 0)) begin
            tick();
            i++;
        end
        chk("frame_done", 64'(exp_state == 0 && sb.size() == 0 && src_q.size() == 0), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tready"}, 64'(tready), 64'd0);
        chk({tag, "_strm_valid"}, 64'(strm_valid), 64'd0);
        chk({tag, "_strm_last"}, 64'(strm_last), 64'd0);
        chk({tag, "_strm_data"}, 64'(strm_data), 64'd0);
        chk({tag, "_axis_finish"}, 64'(axis_finish), 64'd0);
        chk({tag, "_data_cnt"}, 64'(data_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Beats offered before ap_start must stall, then a 5-beat frame streams through.
        fir_ready = 1'b1;
        add_beats(32'h1, 5, 1'b1);
        n_acc = 0;
        repeat (3) tick();
        chk("no_push_idle", 64'(n_acc), 64'd0);
        start_frame();
        run_to_idle(30);
        chk("frame1_beats", 64'(n_acc), 64'd5);
        exp_cnt = 10'd5;
        chk_cnt("frame1_cnt");

        // Backpressure: depth 4 fills, remaining beats accepted once the sink drains.
        fir_ready = 1'b0;
        add_beats(32'h10, 6, 1'b1);
        n_acc = 0;
        start_frame();
        repeat (8) tick();
        chk("acc_while_full", 64'(n_acc), 64'd4);
        chk("tready_full", 64'(tready), 64'd0);
        fir_ready = 1'b1;
        run_to_idle(30);
        chk("frame2_beats", 64'(n_acc), 64'd6);

        // Single-beat frame held at the head while the sink stalls.
        fir_ready = 1'b0;
        add_beats(32'hA, 1, 1'b1);
        start_frame();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_last", 64'(strm_last), 64'd1);
            chk("held_data", 64'(strm_data), 64'hA);
            chk("state_drain", 64'(dut.r_state), 64'(DRAIN));
        end
        fir_ready = 1'b1;
        run_to_idle(10);

        // Reset mid-frame with three beats buffered.
        fir_ready = 1'b0;
        add_beats(32'h31, 3, 1'b0);
        start_frame();
        repeat (4) tick();
        chk("pre_reset_valid", 64'(strm_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        sb.delete();
        src_q.delete();
        exp_state = 0;
        exp_cnt   = '0;
        @(negedge clk);
        chk("reset_no_finish", 64'(axis_finish), 64'd0);
        rst = 1'b0;
        tick();

        // Fresh frame after reset.
        fir_ready = 1'b1;
        add_beats(32'h41, 3, 1'b1);
        n_acc = 0;
        start_frame();
        run_to_idle(30);
        chk("frame4_beats", 64'(n_acc), 64'd3);
        exp_cnt = 10'd3;
        chk_cnt("frame4_cnt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
